// File: rtl/sound_pkg.sv
// Shared constants for the tone datapath and its beep scheduler.
package sound_pkg;

  localparam int FREQ_W        = 52;
  localparam int SHORT_CYC_DEF = 5_000_000;
  localparam int LONG_CYC_DEF  = 25_000_000;
  localparam int GAP_CYC_DEF   = 2_500_000;
  localparam int TONE_DEF      = 32000;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/sound_beep_scheduler_if.sv
// Request/status bundle between beep requesters and the scheduler.
interface sound_beep_scheduler_if #(parameter int NREQ = 4);
  import sound_pkg::*;

  logic [NREQ-1:0]   short_req;
  logic [NREQ-1:0]   long_req;
  logic              mute;
  logic              s_enable;
  logic [FREQ_W-1:0] sonido;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;

  modport master (output short_req, long_req, mute,
                  input  s_enable, sonido, grant, busy, done);
  modport slave  (input  short_req, long_req, mute,
                  output s_enable, sonido, grant, busy, done);
endinterface

// File: rtl/sound_prio_arbiter.sv
// Lowest-index-first one-hot picker over the pending requesters.
module sound_prio_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] onehot,
  output logic            valid
);
  // Isolate the lowest set bit (two's-complement trick)
  always_comb begin
    onehot = req & (~req + {{(NREQ-1){1'b0}}, 1'b1});
    valid  = |req;
  end
endmodule

// File: rtl/sound_beep_scheduler.sv
// Shares one tone generator among NREQ requesters: one-deep short/long
// pending slot per requester, fixed priority, timed beep then timed gap.
module sound_beep_scheduler
  import sound_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SHORT_CYC = SHORT_CYC_DEF,
  parameter int LONG_CYC  = LONG_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int TONE      = TONE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  sound_beep_scheduler_if.slave   bus
);
  localparam int TW = $clog2(LONG_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   pend_s_q, pend_s_d, pend_l_q, pend_l_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              en_q, en_d, done_q, done_d, busy_q, busy_d;
  logic [FREQ_W-1:0] sonido_q, sonido_d;

  logic [NREQ-1:0]   sel, clr_s, clr_l;
  logic              any_pend, pick_long, start;

  sound_prio_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (pend_l_q | pend_s_q),
    .onehot (sel),
    .valid  (any_pend)
  );

  // Next-state: FSM, timer, pending slots and registered outputs
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    en_d      = en_q;
    done_d    = 1'b0;
    clr_s     = '0;
    clr_l     = '0;
    pick_long = |(sel & pend_l_q);
    // A new beep may start from IDLE or from the last cycle of a gap
    start     = any_pend && ((state_q == ST_IDLE) ||
                             (state_q == ST_GAP && timer_q == '0));

    case (state_q)
      ST_PLAY: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          grant_d = '0;
          done_d  = 1'b1;
          timer_d = TW'(GAP_CYC - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q != '0)   timer_d = timer_q - 1'b1;
        else if (!any_pend)  state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (start) begin
      state_d = ST_PLAY;
      grant_d = sel;
      en_d    = 1'b1;
      // Long wins over short for the chosen requester; only that slot clears
      if (pick_long) begin
        clr_l   = sel;
        timer_d = TW'(LONG_CYC - 1);
      end else begin
        clr_s   = sel;
        timer_d = TW'(SHORT_CYC - 1);
      end
    end

    // New pulses win over a same-cycle grant clear
    pend_s_d = (pend_s_q & ~clr_s) | bus.short_req;
    pend_l_d = (pend_l_q & ~clr_l) | bus.long_req;

    // Mute overrides everything, including this cycle's requests
    if (bus.mute) begin
      state_d  = ST_IDLE;
      timer_d  = '0;
      grant_d  = '0;
      en_d     = 1'b0;
      done_d   = 1'b0;
      pend_s_d = '0;
      pend_l_d = '0;
    end

    busy_d   = (state_d != ST_IDLE);
    sonido_d = en_d ? FREQ_W'(TONE) : '0;
  end

  // State and output registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      pend_s_q <= '0;
      pend_l_q <= '0;
      grant_q  <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sonido_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_s_q <= pend_s_d;
      pend_l_q <= pend_l_d;
      grant_q  <= grant_d;
      en_q     <= en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sonido_q <= sonido_d;
    end
  end

  assign bus.s_enable = en_q;
  assign bus.sonido   = sonido_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sound_beep_scheduler.sv
// Bench for sound_beep_scheduler: per-step vector tables built from the
// expected beep schedule, checked through a scoreboard queue.
module tb_sound_beep_scheduler;
  localparam int NREQ  = 4;
  localparam int SHORT = 4;
  localparam int LONG  = 10;
  localparam int GAP   = 2;
  localparam int TONE  = 32000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sound_beep_scheduler_if #(.NREQ(NREQ)) bus ();

  sound_beep_scheduler #(
    .NREQ(NREQ), .SHORT_CYC(SHORT), .LONG_CYC(LONG), .GAP_CYC(GAP), .TONE(TONE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NREQ-1:0] s;
    logic [NREQ-1:0] l;
    logic            m;
    logic            en;
    logic [NREQ-1:0] g;
    logic            busy;
    logic            done;
  } vec_t;

  typedef struct {
    logic            en;
    logic [NREQ-1:0] g;
    logic            busy;
    logic            done;
  } exp_t;

  vec_t vec[64];
  int   nvec;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  task automatic clear_vec(input int n);
    for (int k = 0; k < 64; k++) vec[k] = '{default: '0};
    nvec = n;
  endtask

  // Expected outputs of one beep starting at step st, followed by its gap
  task automatic plan_beep(input int st, input int own, input int len);
    for (int k = st; k < st + len; k++) begin
      vec[k].en   = 1'b1;
      vec[k].g    = NREQ'(1 << own);
      vec[k].busy = 1'b1;
    end
    vec[st + len].done = 1'b1;
    for (int k = st + len; k < st + len + GAP; k++) vec[k].busy = 1'b1;
  endtask

  // Expect silence/idle from step `from` onward
  task automatic cut(input int from);
    for (int k = from; k < 64; k++) begin
      vec[k].en = 1'b0; vec[k].g = '0; vec[k].busy = 1'b0; vec[k].done = 1'b0;
    end
  endtask

  task automatic check_outputs(input string name, input int step, input exp_t e);
    chk({name, ".s_enable"}, step, 64'(bus.s_enable), 64'(e.en));
    chk({name, ".sonido"},   step, 64'(bus.sonido),   e.en ? 64'(TONE) : 64'd0);
    chk({name, ".grant"},    step, 64'(bus.grant),    64'(e.g));
    chk({name, ".busy"},     step, 64'(bus.busy),     64'(e.busy));
    chk({name, ".done"},     step, 64'(bus.done),     64'(e.done));
  endtask

  // Inputs of step k are sampled by the edge after which step k is observed
  task automatic run_vecs(input string name);
    exp_t e;
    for (int k = 0; k < nvec; k++) begin
      @(negedge clk);
      bus.short_req = vec[k].s;
      bus.long_req  = vec[k].l;
      bus.mute      = vec[k].m;
      sb.push_back('{en: vec[k].en, g: vec[k].g, busy: vec[k].busy, done: vec[k].done});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_outputs(name, k, e);
    end
    @(negedge clk);
    bus.short_req = '0;
    bus.long_req  = '0;
    bus.mute      = 1'b0;
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '{en: 1'b0, g: '0, busy: 1'b0, done: 1'b0};
    bus.short_req = '0;
    bus.long_req  = '0;
    bus.mute      = 1'b0;
    reset = 1'b1;
    #1;
    check_outputs("reset_async", 0, zero_e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single short beep from requester 0
    clear_vec(10);
    vec[0].s = 4'b0001;
    plan_beep(1, 0, SHORT);
    run_vecs("short0");

    // Short(req3) + long(req1) together: long for req1, then short for req3 back to back
    clear_vec(21);
    vec[0].s = 4'b1000;
    vec[0].l = 4'b0010;
    plan_beep(1, 1, LONG);
    plan_beep(1 + LONG + GAP, 3, SHORT);
    run_vecs("prio");

    // Re-requests during own PLAY coalesce into one extra beep
    clear_vec(16);
    vec[0].s = 4'b0100;
    vec[2].s = 4'b0100;
    vec[3].s = 4'b0100;
    vec[4].s = 4'b0100;
    plan_beep(1, 2, SHORT);
    plan_beep(1 + SHORT + GAP, 2, SHORT);
    run_vecs("coalesce");

    // Short and long from the same requester: long first, then short
    clear_vec(21);
    vec[0].s = 4'b0001;
    vec[0].l = 4'b0001;
    plan_beep(1, 0, LONG);
    plan_beep(1 + LONG + GAP, 0, SHORT);
    run_vecs("both0");

    // Mute 3 cycles into a long beep; pending and same-cycle requests flushed
    clear_vec(20);
    vec[0].l = 4'b0001;
    vec[1].s = 4'b0001;
    vec[4].m = 1'b1;
    vec[4].s = 4'b0010;
    plan_beep(1, 0, LONG);
    cut(4);
    run_vecs("mute");

    // Async reset mid-PLAY with another requester pending
    clear_vec(4);
    vec[0].l = 4'b0001;
    vec[2].s = 4'b0100;
    plan_beep(1, 0, LONG);
    cut(4);
    run_vecs("pre_reset");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outputs("reset_mid_play", 0, zero_e);
    @(negedge clk);
    reset = 1'b0;
    clear_vec(16);
    run_vecs("post_reset_idle");

    // Normal operation resumes after reset
    clear_vec(10);
    vec[0].s = 4'b1000;
    plan_beep(1, 3, SHORT);
    run_vecs("post_reset_beep");

    chk("scoreboard_empty", 0, 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, got no end expected end");
    $fatal(1);
  end
endmodule
